// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, defaults and address/pattern helpers for the cache traffic cpu
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WORD,
        WR_BYTE,
        RD,
        DRAIN,
        DONE,
        ERROR
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_1000;
    localparam int          DEF_NUM_WORDS  = 8;
    localparam int          DEF_RD_LATENCY = 1;
    localparam logic [31:0] DEF_DATA_SEED  = 32'h1234_5678;

    // Word address of index idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

    // Full-word store pattern.
    function automatic logic [31:0] word_pattern(input logic [31:0] seed, input logic [7:0] idx);
        return seed + {24'd0, idx};
    endfunction

    // Single byte lane written in the byte-masked phase.
    function automatic logic [3:0] byte_sel(input logic [7:0] idx);
        return 4'b0001 << idx[1:0];
    endfunction

    // Byte-phase store data: index replicated so any lane carries it.
    function automatic logic [31:0] byte_pattern(input logic [7:0] idx);
        return {4{idx}};
    endfunction

    // Value a load must return once both store phases have landed.
    function automatic logic [31:0] exp_word(input logic [31:0] seed, input logic [7:0] idx);
        logic [31:0] w;
        w = word_pattern(seed, idx);
        w[{idx[1:0], 3'b000} +: 8] = idx;
        return w;
    endfunction

endpackage

// File: rtl/cpu_rd_checker.sv
// rtl/cpu_rd_checker.sv - fixed-latency expected-value delay line and load-data comparator
module cpu_rd_checker
    import cpu_pkg::*;
#(
    parameter int          RD_LATENCY = DEF_RD_LATENCY,
    parameter logic [31:0] DATA_SEED  = DEF_DATA_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [7:0]  push_idx_i,
    input  logic        push_last_i,
    input  logic [31:0] data_i,
    output logic        mismatch_o,
    output logic        last_checked_o
);

    logic [RD_LATENCY-1:0] valid_q;
    logic [RD_LATENCY-1:0] last_q;
    logic [31:0]           exp_q [RD_LATENCY];
    logic                  match;

    // Shift the expected value alongside the load so it meets the returning data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < RD_LATENCY; k++) exp_q[k] <= '0;
        end else begin
            valid_q[0] <= push_i;
            last_q[0]  <= push_i & push_last_i;
            exp_q[0]   <= exp_word(DATA_SEED, push_idx_i);
            for (int k = 1; k < RD_LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                last_q[k]  <= last_q[k-1];
                exp_q[k]   <= exp_q[k-1];
            end
        end
    end

    assign match          = (data_i == exp_q[RD_LATENCY-1]);
    assign mismatch_o     = valid_q[RD_LATENCY-1] & ~match;
    assign last_checked_o = valid_q[RD_LATENCY-1] & last_q[RD_LATENCY-1] & match;

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - self-running store/byte-store/load traffic generator for data-cache bring-up
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          NUM_WORDS  = DEF_NUM_WORDS,
    parameter int          RD_LATENCY = DEF_RD_LATENCY,
    parameter logic [31:0] DATA_SEED  = DEF_DATA_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dcache_data_i,
    output logic [31:0] dcache_raddr_o,
    output logic [31:0] dcache_waddr_o,
    output logic [31:0] dcache_wdata_o,
    output logic        dcache_wreq_o,
    output logic        dcache_rreq_o,
    output logic [3:0]  dcache_sel_o
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    state_e      state_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_inc;
    logic        is_last;
    logic [31:0] raddr_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        wreq_q;
    logic        rreq_q;
    logic [3:0]  sel_q;
    logic        mismatch;
    logic        last_checked;

    assign idx_inc = idx_q + 8'd1;
    assign is_last = (idx_q == LAST_IDX);

    // The load being presented (rreq_q with idx_q) is the one the cache samples at this edge.
    cpu_rd_checker #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_SEED  (DATA_SEED)
    ) u_rd_checker (
        .clk            (clk),
        .rst            (rst),
        .push_i         (rreq_q),
        .push_idx_i     (idx_q),
        .push_last_i    (is_last),
        .data_i         (dcache_data_i),
        .mismatch_o     (mismatch),
        .last_checked_o (last_checked)
    );

    // Phase sequencer; each edge registers the request for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            sel_q   <= '0;
            case (state_q)
                IDLE: begin
                    state_q <= WR_WORD;
                    idx_q   <= '0;
                    wreq_q  <= 1'b1;
                    waddr_q <= word_addr(BASE_ADDR, 8'd0);
                    wdata_q <= word_pattern(DATA_SEED, 8'd0);
                    sel_q   <= 4'b1111;
                end
                WR_WORD: begin
                    wreq_q <= 1'b1;
                    if (is_last) begin
                        state_q <= WR_BYTE;
                        idx_q   <= '0;
                        waddr_q <= word_addr(BASE_ADDR, 8'd0);
                        wdata_q <= byte_pattern(8'd0);
                        sel_q   <= byte_sel(8'd0);
                    end else begin
                        idx_q   <= idx_inc;
                        waddr_q <= word_addr(BASE_ADDR, idx_inc);
                        wdata_q <= word_pattern(DATA_SEED, idx_inc);
                        sel_q   <= 4'b1111;
                    end
                end
                WR_BYTE: begin
                    if (is_last) begin
                        state_q <= RD;
                        idx_q   <= '0;
                        rreq_q  <= 1'b1;
                        raddr_q <= word_addr(BASE_ADDR, 8'd0);
                        sel_q   <= 4'b1111;
                    end else begin
                        idx_q   <= idx_inc;
                        wreq_q  <= 1'b1;
                        waddr_q <= word_addr(BASE_ADDR, idx_inc);
                        wdata_q <= byte_pattern(idx_inc);
                        sel_q   <= byte_sel(idx_inc);
                    end
                end
                RD: begin
                    if (mismatch) begin
                        state_q <= ERROR;
                    end else if (is_last) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_q   <= idx_inc;
                        rreq_q  <= 1'b1;
                        raddr_q <= word_addr(BASE_ADDR, idx_inc);
                        sel_q   <= 4'b1111;
                    end
                end
                DRAIN: begin
                    if (mismatch) begin
                        state_q <= ERROR;
                    end else if (last_checked) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= DONE;
                ERROR:   state_q <= ERROR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dcache_raddr_o = raddr_q;
    assign dcache_waddr_o = waddr_q;
    assign dcache_wdata_o = wdata_q;
    assign dcache_wreq_o  = wreq_q;
    assign dcache_rreq_o  = rreq_q;
    assign dcache_sel_o   = sel_q;

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for the cache traffic cpu
module tb_cpu;
    import cpu_pkg::*;

    logic        clk;
    logic        rst0, rst1;
    logic [31:0] data0, data1;
    logic [31:0] raddr0, waddr0, wdata0, raddr1, waddr1, wdata1;
    logic        wreq0, rreq0, wreq1, rreq1;
    logic [3:0]  sel0, sel1;

    int n_cmp;
    int n_fail;
    int corrupt_idx;
    int nreq0, nviol0, nreq1;

    logic [31:0] mem0 [8];
    logic [31:0] mem1;
    logic [31:0] rd0;
    logic        rv0, rv1;
    logic [31:0] p1_0, p1_1, p1_2;

    cpu dut0 (
        .clk(clk), .rst(rst0), .dcache_data_i(data0),
        .dcache_raddr_o(raddr0), .dcache_waddr_o(waddr0), .dcache_wdata_o(wdata0),
        .dcache_wreq_o(wreq0), .dcache_rreq_o(rreq0), .dcache_sel_o(sel0)
    );

    cpu #(.NUM_WORDS(1), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst1), .dcache_data_i(data1),
        .dcache_raddr_o(raddr1), .dcache_waddr_o(waddr1), .dcache_wdata_o(wdata1),
        .dcache_wreq_o(wreq1), .dcache_rreq_o(rreq1), .dcache_sel_o(sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model for dut0: byte-masked writes, latency-1 reads, optional corrupted word.
    always begin
        @(negedge clk);
        if (wreq0)
            for (int b = 0; b < 4; b++)
                if (sel0[b]) mem0[waddr0[4:2]][8*b +: 8] = wdata0[8*b +: 8];
        rv0 = rreq0;
        rd0 = mem0[raddr0[4:2]];
        if (rreq0 && int'(raddr0[4:2]) == corrupt_idx) rd0 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        data0 = rv0 ? rd0 : 32'h0;
    end

    // Cache model for dut1: single word, latency-3 reads.
    always begin
        @(negedge clk);
        if (wreq1)
            for (int b = 0; b < 4; b++)
                if (sel1[b]) mem1[8*b +: 8] = wdata1[8*b +: 8];
        rv1 = rreq1;
        @(posedge clk);
        #1;
        p1_2 = p1_1;
        p1_1 = p1_0;
        p1_0 = rv1 ? mem1 : 32'h0;
        data1 = p1_2;
    end

    // Request and idle-value monitors.
    always @(posedge clk) begin
        if (wreq0) nreq0++;
        if (rreq0) nreq0++;
        if (wreq0 && rreq0) nviol0++;
        if (!wreq0 && (waddr0 != 32'h0 || wdata0 != 32'h0)) nviol0++;
        if (!rreq0 && raddr0 != 32'h0) nviol0++;
        if (!wreq0 && !rreq0 && sel0 != 4'h0) nviol0++;
        if (wreq1) nreq1++;
        if (rreq1) nreq1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        int rcount;
        n_cmp = 0; n_fail = 0; corrupt_idx = -1;
        nreq0 = 0; nviol0 = 0; nreq1 = 0;
        data0 = 32'h0; data1 = 32'h0;
        p1_0 = 32'h0; p1_1 = 32'h0; p1_2 = 32'h0;
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset state
        tick(3);
        check("rst_wreq", {31'd0, wreq0}, 32'h0);
        check("rst_rreq", {31'd0, rreq0}, 32'h0);
        check("rst_sel", {28'd0, sel0}, 32'h0);
        check("rst_waddr", waddr0, 32'h0);
        check("rst_wdata", wdata0, 32'h0);
        check("rst_state", 32'(dut0.state_q), 32'(IDLE));
        nreq0 = 0; nviol0 = 0;

        // Full-word phase
        rst0 = 1'b1;
        tick(1);
        check("w0_wreq", {31'd0, wreq0}, 32'h1);
        check("w0_waddr", waddr0, 32'h0000_1000);
        check("w0_wdata", wdata0, 32'h1234_5678);
        check("w0_sel", {28'd0, sel0}, 32'hF);
        tick(7);
        check("w7_waddr", waddr0, 32'h0000_101C);
        check("w7_wdata", wdata0, 32'h1234_567F);

        // Byte phase
        tick(1);
        check("b0_waddr", waddr0, 32'h0000_1000);
        check("b0_sel", {28'd0, sel0}, 32'h1);
        check("b0_wdata", wdata0, 32'h0000_0000);
        tick(1);
        check("b1_waddr", waddr0, 32'h0000_1004);
        check("b1_sel", {28'd0, sel0}, 32'h2);
        check("b1_wdata", wdata0, 32'h0101_0101);
        tick(4);
        check("b5_sel", {28'd0, sel0}, 32'h2);
        check("b5_wdata", wdata0, 32'h0505_0505);

        // Read phase
        tick(3);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rd%0d_rreq", k), {30'd0, wreq0, rreq0}, 32'h1);
            check($sformatf("rd%0d_raddr", k), raddr0, 32'h0000_1000 + 32'(4 * k));
            tick(1);
        end
        c = 0;
        while (!(dut0.state_q inside {DONE, ERROR}) && c < 50) begin tick(1); c++; end
        check("run_done", 32'(dut0.state_q), 32'(DONE));
        check("done_outs", {raddr0 | waddr0 | wdata0, 32'(sel0), 32'({wreq0, rreq0})}, 96'h0);
        check("mem_w0", mem0[0], 32'h1234_5600);
        check("mem_w1", mem0[1], 32'h1234_0179);
        check("mem_w5", mem0[5], 32'h1234_057D);
        check("req_total", nreq0, 24);
        check("idle_viol", nviol0, 0);

        // Corrupted read of word 3
        rst0 = 1'b0;
        corrupt_idx = 3;
        tick(2);
        rst0 = 1'b1;
        c = 0;
        while (!(rreq0 && raddr0 == 32'h0000_100C) && c < 100) begin tick(1); c++; end
        check("wait_rd3", {31'd0, c < 100}, 32'h1);
        tick(1);
        check("cmp_cycle_state", 32'(dut0.state_q), 32'(RD));
        tick(1);
        check("err_state", 32'(dut0.state_q), 32'(ERROR));
        rcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (rreq0) rcount++;
            tick(1);
        end
        check("no_rreq_after_err", rcount, 0);
        check("err_hold", 32'(dut0.state_q), 32'(ERROR));

        // Reset during byte phase
        rst0 = 1'b0;
        corrupt_idx = -1;
        tick(2);
        rst0 = 1'b1;
        c = 0;
        while (!(wreq0 && sel0 == 4'b0010 && wdata0 == 32'h0101_0101) && c < 100) begin tick(1); c++; end
        check("wait_b1", {31'd0, c < 100}, 32'h1);
        rst0 = 1'b0;
        tick(1);
        check("midrst_outs", {raddr0 | waddr0 | wdata0, 32'(sel0), 32'({wreq0, rreq0})}, 96'h0);
        check("midrst_state", 32'(dut0.state_q), 32'(IDLE));
        rst0 = 1'b1;
        tick(1);
        check("restart_wreq", {31'd0, wreq0}, 32'h1);
        check("restart_waddr", waddr0, 32'h0000_1000);
        check("restart_wdata", wdata0, 32'h1234_5678);
        c = 0;
        while (!(dut0.state_q inside {DONE, ERROR}) && c < 100) begin tick(1); c++; end
        check("restart_done", 32'(dut0.state_q), 32'(DONE));

        // Latency 3, single word
        nreq1 = 0;
        rst1 = 1'b1;
        c = 0;
        while (!rreq1 && c < 50) begin tick(1); c++; end
        check("l3_wait_rreq", {31'd0, c < 50}, 32'h1);
        check("l3_raddr", raddr1, 32'h0000_1000);
        tick(3);
        check("l3_drain", 32'(dut1.state_q), 32'(DRAIN));
        tick(1);
        check("l3_done", 32'(dut1.state_q), 32'(DONE));
        tick(2);
        check("l3_req_total", nreq1, 3);
        check("l3_mem", mem1, 32'h1234_5600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
